// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - RV32I decode/issue stage with busy-bit scoreboard and ID/EX register
//
// Purpose:
//   Decodes the fetched instruction and drives the register file read
//   addresses combinationally. Issued instructions are captured into an
//   ID/EX register together with their operands and sign-extended immediate.
//   A per-register busy scoreboard holds issue back on RAW/WAW hazards until
//   the producing write reaches the register file write port.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   if_valid/if_ready fetch handshake; if_instr/if_pc the offered instruction
//   ra1, ra2          register file read addresses (combinational from if_instr)
//   rd1, rd2          register file read data for ra1/ra2
//   wb_we, wb_addr    register file write port strobe/address (clears busy)
//   flush             kills the instruction held in ID/EX
//   ex_valid/ex_ready ID/EX handshake toward execute
//   ex_*              captured pc, operands, immediate and decoded fields

module decode_issue #(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_illegal
);

  localparam int NREG = 2 ** ADDR_W;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  // Instruction fields
  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic [ADDR_W-1:0] w_rd;

  // Decode results
  imm_fmt_t          w_fmt;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_writes_rd;
  logic              w_illegal;
  logic [31:0]       w_imm32;
  logic [XLEN-1:0]   w_imm;

  // Handshake and scoreboard
  logic              w_hazard;
  logic              w_accept;
  logic [NREG-1:0]   w_busy_nxt;

  // State
  logic [NREG-1:0]   r_busy;
  logic              r_ex_valid;
  logic              r_ex_wr;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_op1;
  logic [XLEN-1:0]   r_ex_op2;
  logic [XLEN-1:0]   r_ex_imm;
  logic [ADDR_W-1:0] r_ex_rd;
  logic [6:0]        r_ex_opcode;
  logic [2:0]        r_ex_funct3;
  logic              r_ex_funct7b5;
  logic              r_ex_illegal;

  assign w_opcode = if_instr[6:0];
  assign w_funct3 = if_instr[14:12];
  assign w_rs1    = ADDR_W'(if_instr[19:15]);
  assign w_rs2    = ADDR_W'(if_instr[24:20]);
  assign w_rd     = ADDR_W'(if_instr[11:7]);

  assign ra1 = w_rs1;
  assign ra2 = w_rs2;

  // Opcode decode: immediate format and register usage
  always_comb begin
    w_fmt       = IMM_NONE;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_writes_rd = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_fmt       = IMM_U;
        w_writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        w_fmt       = IMM_U;
        w_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        w_fmt       = IMM_J;
        w_writes_rd = 1'b1;
      end
      OPC_JALR: begin
        w_fmt       = IMM_I;
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt      = IMM_B;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        w_fmt       = IMM_I;
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_STORE: begin
        w_fmt      = IMM_S;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        w_fmt       = IMM_I;
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_OP: begin
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
        w_writes_rd = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    // x0 is never a real destination, so it must never mark a register busy
    if (w_rd == '0) begin
      w_writes_rd = 1'b0;
    end
  end

  // Immediate assembly; every format is sign-extended from instr[31]
  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      IMM_I: w_imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      IMM_S: w_imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      IMM_B: w_imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                        if_instr[30:25], if_instr[11:8], 1'b0};
      IMM_U: w_imm32 = {if_instr[31:12], 12'd0};
      IMM_J: w_imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                        if_instr[20], if_instr[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // r_busy[0] is held at zero, so x0 sources never raise a hazard
  assign w_hazard = if_valid && ((w_uses_rs1  && r_busy[w_rs1]) ||
                                 (w_uses_rs2  && r_busy[w_rs2]) ||
                                 (w_writes_rd && r_busy[w_rd]));

  assign if_ready = !reset && !flush && !w_hazard && (!r_ex_valid || ex_ready);
  assign w_accept = if_valid && if_ready;

  // Scoreboard update. Ordering matters: the issue-side set is applied last
  // so that it wins over a write-back clear to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_we && (wb_addr != '0)) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    // A flushed producer will never write back, so release its destination
    if (flush && r_ex_valid && r_ex_wr) begin
      w_busy_nxt[r_ex_rd] = 1'b0;
    end
    if (w_accept && w_writes_rd) begin
      w_busy_nxt[w_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy        <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_wr       <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_op1      <= '0;
      r_ex_op2      <= '0;
      r_ex_imm      <= '0;
      r_ex_rd       <= '0;
      r_ex_opcode   <= '0;
      r_ex_funct3   <= '0;
      r_ex_funct7b5 <= 1'b0;
      r_ex_illegal  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        r_ex_valid    <= 1'b1;
        r_ex_wr       <= w_writes_rd;
        r_ex_pc       <= if_pc;
        r_ex_op1      <= rd1;
        r_ex_op2      <= rd2;
        r_ex_imm      <= w_imm;
        r_ex_rd       <= w_rd;
        r_ex_opcode   <= w_opcode;
        r_ex_funct3   <= w_funct3;
        r_ex_funct7b5 <= if_instr[30];
        r_ex_illegal  <= w_illegal;
      end else if (flush || ex_ready) begin
        // Consumed or killed with nothing behind it; data fields hold
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_op1      = r_ex_op1;
  assign ex_op2      = r_ex_op2;
  assign ex_imm      = r_ex_imm;
  assign ex_rd       = r_ex_rd;
  assign ex_opcode   = r_ex_opcode;
  assign ex_funct3   = r_ex_funct3;
  assign ex_funct7b5 = r_ex_funct7b5;
  assign ex_illegal  = r_ex_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed scoreboard bench for decode_issue

module tb_decode_issue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] rd;
    logic [31:0] opcode;
    logic [31:0] funct3;
    logic [31:0] f7b5;
    logic [31:0] ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_illegal;

  logic [31:0] regs [32];
  exp_t        sb [$];
  logic [31:0] cur_imm;
  logic        cur_ill;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_issue #(.ADDR_W(5), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal)
  );

  // Register file model: reloads known contents while reset is high
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ex_pc",      ex_pc,              e.pc);
        chk("ex_op1",     ex_op1,             e.op1);
        chk("ex_op2",     ex_op2,             e.op2);
        chk("ex_imm",     ex_imm,             e.imm);
        chk("ex_rd",      32'(ex_rd),         e.rd);
        chk("ex_opcode",  32'(ex_opcode),     e.opcode);
        chk("ex_funct3",  32'(ex_funct3),     e.funct3);
        chk("ex_funct7b5", 32'(ex_funct7b5),  e.f7b5);
        chk("ex_illegal", 32'(ex_illegal),    e.ill);
      end
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] imm, input logic ill);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    cur_imm  = imm;
    cur_ill  = ill;
  endtask

  // One clock cycle: entered 1 time unit after a rising edge, checks the
  // handshake mid-cycle, pushes the expected issue, returns after the edge.
  task automatic cyc(input logic exp_rdy);
    exp_t e;
    #2;
    chk("if_ready", 32'(if_ready), 32'(exp_rdy));
    sample();
    if (if_valid && exp_rdy) begin
      e.pc     = if_pc;
      e.op1    = regs[if_instr[19:15]];
      e.op2    = regs[if_instr[24:20]];
      e.imm    = cur_imm;
      e.rd     = 32'(if_instr[11:7]);
      e.opcode = 32'(if_instr[6:0]);
      e.funct3 = 32'(if_instr[14:12]);
      e.f7b5   = 32'(if_instr[30]);
      e.ill    = 32'(cur_ill);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic exp_rdy);
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = d;
    cyc(exp_rdy);
    wb_we   = 1'b0;
  endtask

  initial begin
    if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    flush = 1'b0; ex_ready = 1'b1;
    cur_imm = 32'd0; cur_ill = 1'b0;

    // Reset: asynchronous, before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc",    ex_pc,         32'd0);
    chk("rst_ex_imm",   ex_imm,        32'd0);
    chk("rst_ex_rd",    32'(ex_rd),    32'd0);
    chk("rst_ex_ill",   32'(ex_illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // RAW stall: ADDI x5,x0,7 then ADD x6,x5,x5
    drive(32'h00700293, 32'h100, 32'd7, 1'b0);
    cyc(1'b1);
    drive(32'h00528333, 32'h104, 32'd0, 1'b0);
    cyc(1'b0);
    cyc(1'b0);
    wb(5'd5, 32'h0000ABCD, 1'b0);
    cyc(1'b1);
    if_valid = 1'b0;
    wb(5'd6, 32'h66, 1'b1);
    cyc(1'b1);

    // Back-pressure: held instruction stays put, next one waits
    drive(32'h05500413, 32'h200, 32'h55, 1'b0);
    cyc(1'b1);
    ex_ready = 1'b0;
    drive(32'h00100493, 32'h204, 32'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0);
      chk("bp_ex_valid", 32'(ex_valid), 32'd1);
      chk("bp_ex_pc",    ex_pc,         32'h200);
      chk("bp_ex_imm",   ex_imm,        32'h55);
      chk("bp_ex_rd",    32'(ex_rd),    32'd8);
    end
    ex_ready = 1'b1;
    cyc(1'b1);
    if_valid = 1'b0;
    cyc(1'b1);
    wb(5'd8, 32'h88, 1'b1);
    wb(5'd9, 32'h99, 1'b1);

    // x0 destination: back-to-back, no busy bit
    drive(32'h00000013, 32'h300, 32'd0, 1'b0);
    cyc(1'b1);
    drive(32'h00000333, 32'h304, 32'd0, 1'b0);
    cyc(1'b1);
    if_valid = 1'b0;
    cyc(1'b1);
    wb(5'd6, 32'h660, 1'b1);

    // Immediate formats and illegal opcode
    drive(32'hFE20AE23, 32'h400, 32'hFFFFFFFC, 1'b0);
    #1;
    chk("sw_ra1", 32'(ra1), 32'd1);
    chk("sw_ra2", 32'(ra2), 32'd2);
    cyc(1'b1);
    drive(32'h123450B7, 32'h404, 32'h12345000, 1'b0);
    cyc(1'b1);
    drive(32'hFE418CE3, 32'h408, 32'hFFFFFFF8, 1'b0);
    cyc(1'b1);
    drive(32'h0080006F, 32'h40C, 32'd8, 1'b0);
    cyc(1'b1);
    drive(32'hFFFFF017, 32'h410, 32'hFFFFF000, 1'b0);
    cyc(1'b1);
    drive(32'hFFF00513, 32'h414, 32'hFFFFFFFF, 1'b0);
    cyc(1'b1);
    drive(32'hFE5282FF, 32'h418, 32'd0, 1'b1);
    cyc(1'b1);
    drive(32'h00528333, 32'h41C, 32'd0, 1'b0);
    cyc(1'b1);
    if_valid = 1'b0;
    cyc(1'b1);
    wb(5'd1, 32'h11, 1'b1);
    wb(5'd10, 32'hAA, 1'b1);
    wb(5'd6, 32'h6600, 1'b1);

    // Flush releases the killed producer's destination
    ex_ready = 1'b0;
    drive(32'h00300393, 32'h500, 32'd3, 1'b0);
    cyc(1'b1);
    drive(32'h007385B3, 32'h504, 32'd0, 1'b0);
    flush = 1'b1;
    void'(sb.pop_front());
    cyc(1'b0);
    flush = 1'b0;
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    ex_ready = 1'b1;
    cyc(1'b1);
    if_valid = 1'b0;
    cyc(1'b1);
    wb(5'd11, 32'hBB, 1'b1);

    // Reset while a consumer is stalled behind a held producer
    ex_ready = 1'b0;
    drive(32'h00700293, 32'h600, 32'd7, 1'b0);
    cyc(1'b1);
    drive(32'h00528333, 32'h604, 32'd0, 1'b0);
    cyc(1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_ex_pc",    ex_pc,         32'd0);
    chk("mid_rst_ex_rd",    32'(ex_rd),    32'd0);
    chk("mid_rst_if_ready", 32'(if_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    ex_ready = 1'b1;
    cyc(1'b1);
    if_valid = 1'b0;
    cyc(1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
